// File: rtl/serial_pkg.sv
// Shared types and sizes for the serial byte framer and its output FIFO.
package serial_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned ENTRY_W    = BYTE_W + 1;

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StParity,
        StStop,
        StBreak
    } state_e;

endpackage

// File: rtl/byte_fifo2.sv
// Two-entry FIFO holding {data, perr}; a pop frees room for a same-cycle push.
module byte_fifo2
    import serial_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic [ENTRY_W-1:0] i_data,
    output logic [ENTRY_W-1:0] o_data,
    output logic               o_full,
    output logic               o_empty
);

    localparam logic [1:0] CNT_FULL = 2'(FIFO_DEPTH);

    logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic               r_rd_ptr;
    logic               r_wr_ptr;
    logic [1:0]         r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == 2'd0);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    // When full, the write slot equals the head slot, which the pop vacates this cycle.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/serial_byte_framer.sv
// MSB-first serial deframer: start bit, 8 data bits, optional parity, stop bit,
// with completed bytes queued in a two-entry FIFO.
module serial_byte_framer
    import serial_pkg::*;
#(
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_si,
    input  logic              i_si_en,
    output logic [BYTE_W-1:0] o_byte_out,
    output logic              o_byte_perr,
    output logic              o_byte_valid,
    input  logic              i_byte_ready,
    output logic              o_frame_err,
    output logic              o_overrun,
    output logic              o_busy
);

    localparam logic PARITY_ODD_BIT = (PARITY_ODD != 0);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_nxt;
    logic [BYTE_W-1:0] r_sh;
    logic [BYTE_W-1:0] w_sh_nxt;
    logic              r_perr;
    logic              w_perr_nxt;
    logic              r_frame_err;
    logic              r_overrun;
    logic              w_push;
    logic              w_frame_bad;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [ENTRY_W-1:0] w_head;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sh_nxt    = r_sh;
        w_perr_nxt  = r_perr;
        w_push      = 1'b0;
        w_frame_bad = 1'b0;
        if (i_si_en) begin
            unique case (r_state)
                StIdle: begin
                    if (!i_si) begin
                        w_cnt_nxt   = 3'd0;
                        w_state_nxt = StData;
                    end
                end
                StData: begin
                    w_sh_nxt  = {r_sh[BYTE_W-2:0], i_si};
                    w_cnt_nxt = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        w_state_nxt = (PARITY_EN != 0) ? StParity : StStop;
                    end
                end
                StParity: begin
                    w_perr_nxt  = (^{r_sh, i_si}) ^ PARITY_ODD_BIT;
                    w_state_nxt = StStop;
                end
                StStop: begin
                    if (i_si) begin
                        w_push      = 1'b1;
                        w_state_nxt = StIdle;
                    end else begin
                        w_frame_bad = 1'b1;
                        w_state_nxt = StBreak;
                    end
                end
                StBreak: begin
                    // Line must return high before another start bit can be seen.
                    if (i_si) begin
                        w_state_nxt = StIdle;
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= StIdle;
            r_cnt       <= 3'd0;
            r_sh        <= '0;
            r_perr      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sh        <= w_sh_nxt;
            r_perr      <= w_perr_nxt;
            r_frame_err <= w_frame_bad;
            r_overrun   <= w_push & w_full & ~w_pop;
        end
    end

    assign w_pop = o_byte_valid & i_byte_ready;

    byte_fifo2 u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({r_sh, r_perr}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_byte_out   = w_head[ENTRY_W-1:1];
    assign o_byte_perr  = w_head[0];
    assign o_byte_valid = ~w_empty;
    assign o_frame_err  = r_frame_err;
    assign o_overrun    = r_overrun;
    assign o_busy       = (r_state != StIdle);

endmodule
